decode_stall_ctrl: RTL

- Decode-side partner of the fetch stage. Consumes the fetch outputs (PC, IR, valid) and drives back the two stall signals fetch obeys: dependency stall and branch stall.
- Keeps a per-register scoreboard of in-flight writers and a branch-pending state.
- Issues hazard-free instructions into a registered decode/execute latch.

---
 rtl/decode_stall_ctrl_pkg.sv | 43 ++++
 rtl/decode_scoreboard.sv | 38 +++
 rtl/decode_stall_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/decode_stall_ctrl_pkg.sv
// Shared decode definitions: opcodes, IR field positions, NOP encoding.
package decode_stall_ctrl_pkg;

  localparam int REG_IDX_W = 4;

  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_ADDI = 8'h01;
  localparam logic [7:0] OP_BRZ  = 8'h20;
  localparam logic [7:0] OP_JMP  = 8'h21;
  localparam logic [7:0] OP_NOP  = 8'hFF;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 24;
  localparam int DST_HI  = 23;
  localparam int DST_LO  = 20;
  localparam int SRC1_HI = 19;
  localparam int SRC1_LO = 16;
  localparam int SRC2_HI = 11;
  localparam int SRC2_LO = 8;

  localparam logic [31:0] NOP_IR = 32'hFF000000;

  typedef struct packed {
    logic wr_dst;
    logic rd_src1;
    logic rd_src2;
    logic is_br;
  } op_class_t;

  function automatic op_class_t classify(input logic [7:0] opc);
    op_class_t c;
    c = '0;
    case (opc)
      OP_ADD:  begin c.wr_dst = 1'b1; c.rd_src1 = 1'b1; c.rd_src2 = 1'b1; end
      OP_ADDI: begin c.wr_dst = 1'b1; c.rd_src1 = 1'b1; end
      OP_BRZ:  begin c.is_br = 1'b1; c.rd_src1 = 1'b1; end
      OP_JMP:  c.is_br = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Busy bit per GPR; set wins over same-cycle clear, and queries see
// a same-cycle writeback as already complete.
module decode_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [IDX_W-1:0]     set_idx,
  input  logic                 clr_en,
  input  logic [IDX_W-1:0]     clr_idx,
  input  logic [2:0][IDX_W-1:0] q_idx,
  output logic [2:0]           q_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
  end

  always_comb begin
    q_busy = '0;
    for (int i = 0; i < 3; i++) begin
      q_busy[i] = busy_q[q_idx[i]] & ~(clr_en & (clr_idx == q_idx[i]));
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

endmodule

// File: rtl/decode_stall_ctrl.sv
// Decode stage: hazard detection, branch hold-off and the decode/execute latch.
// Optional stall counters are built when DECODE_STALL_CNT_EN is defined.
module decode_stall_ctrl #(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = decode_stall_ctrl_pkg::REG_IDX_W,
  parameter int PC_WIDTH  = 16,
  parameter int IR_WIDTH  = 32
) (
  input  logic                 I_CLOCK,
  input  logic                 I_LOCK,
  input  logic [PC_WIDTH-1:0]  I_PC,
  input  logic [IR_WIDTH-1:0]  I_IR,
  input  logic                 I_FE_Valid,
  input  logic                 I_BranchAddrSelect,
  input  logic                 I_WBValid,
  input  logic [REG_IDX_W-1:0] I_WBDestReg,
  output logic                 O_LOCK,
  output logic                 O_DepStallSignal,
  output logic                 O_BranchStallSignal,
  output logic [PC_WIDTH-1:0]  O_PC,
  output logic [IR_WIDTH-1:0]  O_IR,
  output logic                 O_DE_Valid,
  output logic [REG_IDX_W-1:0] O_DestReg,
  output logic [REG_IDX_W-1:0] O_Src1Reg,
  output logic [REG_IDX_W-1:0] O_Src2Reg,
  output logic [31:0]          O_DepStallCount,
  output logic [31:0]          O_BrStallCount
);

  import decode_stall_ctrl_pkg::*;

  op_class_t            cls;
  logic [REG_IDX_W-1:0] dst, src1, src2;
  logic [2:0]           q_busy;
  logic                 dep, issue;
  logic                 unused_ir;

  logic                 lock_q, br_q, br_d, valid_q, valid_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [IR_WIDTH-1:0]  ir_q, ir_d;
  logic [REG_IDX_W-1:0] dst_q, dst_d, s1_q, s1_d, s2_q, s2_d;

  assign cls  = classify(I_IR[OPC_HI:OPC_LO]);
  assign dst  = I_IR[DST_HI:DST_LO];
  assign src1 = I_IR[SRC1_HI:SRC1_LO];
  assign src2 = I_IR[SRC2_HI:SRC2_LO];
  assign unused_ir = ^{I_IR[15:12], I_IR[7:0]};

  decode_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (REG_IDX_W)
  ) u_sb (
    .clk     (I_CLOCK),
    .rst_n   (I_LOCK),
    .set_en  (issue & cls.wr_dst),
    .set_idx (dst),
    .clr_en  (I_WBValid),
    .clr_idx (I_WBDestReg),
    .q_idx   ({dst, src2, src1}),
    .q_busy  (q_busy)
  );

  // Squashed slots behind a pending branch never raise a dependency stall.
  always_comb begin
    dep = I_LOCK & I_FE_Valid & ~br_q &
          ((cls.rd_src1 & q_busy[0]) |
           (cls.rd_src2 & q_busy[1]) |
           (cls.wr_dst  & q_busy[2]));
    issue = I_LOCK & I_FE_Valid & ~br_q & ~dep;
  end

  assign O_DepStallSignal    = dep;
  assign O_BranchStallSignal = br_q | (issue & cls.is_br);

  always_comb begin
    br_d    = br_q;
    valid_d = issue;
    pc_d    = pc_q;
    ir_d    = ir_q;
    dst_d   = dst_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    if (issue & cls.is_br)    br_d = 1'b1;
    else if (I_BranchAddrSelect) br_d = 1'b0;
    if (issue) begin
      pc_d  = I_PC;
      ir_d  = I_IR;
      dst_d = dst;
      s1_d  = src1;
      s2_d  = src2;
    end
  end

  always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      lock_q  <= 1'b0;
      br_q    <= 1'b0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      ir_q    <= NOP_IR;
      dst_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
    end else begin
      lock_q  <= I_LOCK;
      br_q    <= br_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      dst_q   <= dst_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

  assign O_LOCK     = lock_q;
  assign O_PC       = pc_q;
  assign O_IR       = ir_q;
  assign O_DE_Valid = valid_q;
  assign O_DestReg  = dst_q;
  assign O_Src1Reg  = s1_q;
  assign O_Src2Reg  = s2_q;

`ifdef DECODE_STALL_CNT_EN
  logic [31:0] dep_cnt_q, dep_cnt_d, br_cnt_q, br_cnt_d;

  always_comb begin
    dep_cnt_d = dep_cnt_q;
    br_cnt_d  = br_cnt_q;
    if (dep && dep_cnt_q != 32'hFFFFFFFF) dep_cnt_d = dep_cnt_q + 32'd1;
    if (br_q && br_cnt_q != 32'hFFFFFFFF) br_cnt_d = br_cnt_q + 32'd1;
  end

  always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      dep_cnt_q <= '0;
      br_cnt_q  <= '0;
    end else begin
      dep_cnt_q <= dep_cnt_d;
      br_cnt_q  <= br_cnt_d;
    end
  end

  assign O_DepStallCount = dep_cnt_q;
  assign O_BrStallCount  = br_cnt_q;
`else
  assign O_DepStallCount = '0;
  assign O_BrStallCount  = '0;
`endif

endmodule
